adder_pipe: RTL

- Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake on both the input and output sides.
- The N-bit operation is split into STAGES equal chunks; each pipeline stage adds one chunk and registers its carry into the next stage.
- Purpose: long adders close timing at high clock rates while still accepting one operation per cycle.
- Sits between operand producers and result consumers in datapath blocks that need throughput rather than single-cycle latency.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_stage.sv | 33 +++
 rtl/full_adder.sv | 13 +
 rtl/adder_pipe.sv | 113 +++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package adder_pkg;

    // Operation selected on the input side; only used before stage 0.
    typedef enum logic {
        ModeAdd = 1'b0,
        ModeSub = 1'b1
    } mode_e;

    // Width of one pipeline chunk. A zero stage count returns n so that the
    // parameter check in the top can still report the problem cleanly.
    function automatic int unsigned chunk_width(input int unsigned n,
                                                input int unsigned stages);
        if (stages == 0) begin
            return n;
        end
        return n / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// W-bit ripple chunk adder; also exposes the carry into its MSB so the
// final stage can derive signed overflow.
module adder_stage
    import adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the leaf cell of every chunk adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_pipe.sv
// Pipelined N-bit adder/subtractor. Each of STAGES stages adds one W-bit
// chunk and hands its carry forward; operand chunks not yet added and sum
// chunks already produced travel alongside in the stage record.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned W = chunk_width(N, STAGES);

    if (N < 1 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("adder_pipe: need N >= 1, 1 <= STAGES <= N and STAGES dividing N");
    end

    // One pipeline slot: chunk k of sum is filled by stage k, chunk k of the
    // operands is cleared once consumed.
    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic                     ovf;
        logic [STAGES-1:0][W-1:0] sum;
        logic [STAGES-1:0][W-1:0] a;
        logic [STAGES-1:0][W-1:0] b;
    } stage_t;

    stage_t in_rec;
    stage_t stage_out [STAGES];
    logic   en;
    mode_e  mode;

    assign mode     = mode_e'(sub);
    // Whole pipe advances unless a finished result is waiting on the consumer.
    assign en       = ~stage_out[STAGES-1].valid | out_ready;
    assign in_ready = en;

    // Build the input record; subtract becomes a + ~b + 1 so stages only add.
    always_comb begin
        in_rec       = '0;
        in_rec.valid = in_valid;
        in_rec.carry = (mode == ModeSub) ? 1'b1 : cin;
        in_rec.a     = a;
        in_rec.b     = (mode == ModeSub) ? ~b : b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t       src;
        stage_t       rec_d;
        stage_t       rec_q;
        logic [W-1:0] sum_chunk;
        logic         co;
        logic         cmsb;

        if (k == 0) begin : g_first
            assign src = in_rec;
        end else begin : g_next
            assign src = stage_out[k-1];
        end

        adder_stage #(
            .W (W)
        ) u_stage (
            .a    (src.a[k]),
            .b    (src.b[k]),
            .cin  (src.carry),
            .s    (sum_chunk),
            .cout (co),
            .cmsb (cmsb)
        );

        // Retire chunk k: record its sum, drop its operands, pass the carry on.
        always_comb begin
            rec_d        = src;
            rec_d.carry  = co;
            rec_d.sum[k] = sum_chunk;
            rec_d.a[k]   = '0;
            rec_d.b[k]   = '0;
            rec_d.ovf    = (k == STAGES - 1) ? (co ^ cmsb) : 1'b0;
        end

        // Stage register; reset clears valid and the visible result fields.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rec_q <= '0;
            end else if (en) begin
                rec_q <= rec_d;
            end
        end

        assign stage_out[k] = rec_q;
    end

    assign out_valid = stage_out[STAGES-1].valid;
    assign s         = stage_out[STAGES-1].sum;
    assign cout      = stage_out[STAGES-1].carry;
    assign ovf       = stage_out[STAGES-1].ovf;

endmodule
